// File: rtl/proc_pkg.sv
// proc_pkg: shared control-bit indices, forwarding encodings and hazard-controller types.
package proc_pkg;
  localparam int CTRL_JUMP = 7;
  localparam int CTRL_LOAD = 6;
  localparam int CTRL_MEMW = 5;
  localparam int CTRL_WRITE = 4;
  localparam int CTRL_BRCOND = 3;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10, FWD_WB = 2'b11} fwd_e;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;
  typedef struct packed {
    logic valid;
    logic write;
    logic load;
    logic [3:0] dst;
  } sb_t;
  // Youngest producer wins; a load still in EX has no data yet, so it never forwards from EX.
  function automatic fwd_e fwd_pick(input logic used, input logic [3:0] src, input logic ex_hit,
                                    input logic [3:0] ex_dst, input sb_t mem, input sb_t wb);
    return !used ? FWD_RF :
           (ex_hit && ex_dst == src) ? FWD_EX :
           (mem.valid && mem.write && mem.dst == src) ? FWD_MEM :
           (wb.valid && wb.write && wb.dst == src) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: OF/EX/ALU inputs and hazard-control outputs of the execute-stage controller.
interface ex_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic of_valid;
  logic [3:0] of_src1;
  logic [3:0] of_src2;
  logic of_src1_used;
  logic of_src2_used;
  logic ex_valid;
  logic [7:0] ex_ctrl;
  logic [3:0] ex_dst;
  logic [8:0] branch_in;
  logic stall;
  logic bubble;
  logic flush;
  logic [1:0] fwd1_sel;
  logic [1:0] fwd2_sel;
  logic redirect_valid;
  logic [7:0] redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output of_valid, of_src1, of_src2, of_src1_used, of_src2_used, ex_valid, ex_ctrl, ex_dst, branch_in,
    input stall, bubble, flush, fwd1_sel, fwd2_sel, redirect_valid, redirect_pc, stall_cnt, flush_cnt
  );
  modport slave (
    input of_valid, of_src1, of_src2, of_src1_used, of_src2_used, ex_valid, ex_ctrl, ex_dst, branch_in,
    output stall, bubble, flush, fwd1_sel, fwd2_sel, redirect_valid, redirect_pc, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(parameter int W = 16) (
  input logic clk,
  input logic reset,
  input logic inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= reset ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: operand forwarding, load-use stall/bubble and taken-branch flush sequencing for EX.
module ex_hazard_ctrl
  import proc_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  ex_hazard_ctrl_if.slave bus
);
  localparam logic [7:0] CNT_START = 8'(FLUSH_CYCLES - 1);
  state_e state, state_n;
  logic [7:0] cnt, cnt_n;
  sb_t mem, wb;
  logic bubble_q, taken, load_use, ex_hit;
  logic unused;
  assign unused = ^{bus.ex_ctrl[CTRL_JUMP], bus.ex_ctrl[CTRL_MEMW], bus.ex_ctrl[CTRL_BRCOND], bus.ex_ctrl[2:0]};
  always_comb begin
    ex_hit = bus.ex_valid & bus.ex_ctrl[CTRL_WRITE] & ~bus.ex_ctrl[CTRL_LOAD];
    load_use = bus.of_valid & bus.ex_valid & bus.ex_ctrl[CTRL_LOAD] & bus.ex_ctrl[CTRL_WRITE] &
               ((bus.of_src1_used & (bus.of_src1 == bus.ex_dst)) | (bus.of_src2_used & (bus.of_src2 == bus.ex_dst)));
    taken = (state == RUN) & bus.ex_valid & bus.branch_in[8];
    bus.stall = (state == RUN) & load_use & ~taken;
    bus.bubble = bus.stall;
    bus.flush = taken | (state == FLUSH);
    bus.redirect_valid = taken;
    bus.redirect_pc = taken ? bus.branch_in[7:0] : 8'h00;
    bus.fwd1_sel = fwd_pick(bus.of_valid & bus.of_src1_used, bus.of_src1, ex_hit, bus.ex_dst, mem, wb);
    bus.fwd2_sel = fwd_pick(bus.of_valid & bus.of_src2_used, bus.of_src2, ex_hit, bus.ex_dst, mem, wb);
    state_n = state;
    cnt_n = cnt;
    if (taken) begin
      state_n = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_n = CNT_START;
    end else if (state == FLUSH) begin
      state_n = (cnt == 8'd1) ? RUN : FLUSH;
      cnt_n = cnt - 8'd1;
    end
  end
  // The cycle after a bubble, EX holds the injected NOP, so its contents must not enter the scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      mem <= '0;
      wb <= '0;
      bubble_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wb <= mem;
      mem <= sb_t'{valid: bus.ex_valid & ~bubble_q, write: bus.ex_ctrl[CTRL_WRITE],
                   load: bus.ex_ctrl[CTRL_LOAD], dst: bus.ex_dst};
      bubble_q <= bus.bubble;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(bus.stall), .q(bus.stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(bus.redirect_valid), .q(bus.flush_cnt));
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed vector table plus reset-mid-flush and counter-saturation sequences.
module tb_ex_hazard_ctrl;
  typedef struct {
    logic ofv;
    logic [3:0] s1, s2;
    logic u1, u2, exv;
    logic [7:0] ctrl;
    logic [3:0] dst;
    logic [8:0] br;
    logic st, bu, fl;
    logic [1:0] f1, f2;
    logic fx;
    logic rv;
    logic [7:0] rpc;
    logic [15:0] sc, fc;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  vec_t tbl[16];
  ex_hazard_ctrl_if #(.CNT_W(16)) bus ();
  ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic drive(input vec_t v);
    bus.of_valid = v.ofv;
    bus.of_src1 = v.s1;
    bus.of_src2 = v.s2;
    bus.of_src1_used = v.u1;
    bus.of_src2_used = v.u2;
    bus.ex_valid = v.exv;
    bus.ex_ctrl = v.ctrl;
    bus.ex_dst = v.dst;
    bus.branch_in = v.br;
  endtask
  initial begin
    tbl[0]  = '{0,0,0,0,0,0,8'h00,0,9'h000, 0,0,0,0,0,0,0,8'h00,0,0};
    tbl[1]  = '{1,3,0,1,0,1,8'h11,3,9'h000, 0,0,0,1,0,0,0,8'h00,0,0};
    tbl[2]  = '{0,0,0,0,0,1,8'h10,5,9'h000, 0,0,0,0,0,0,0,8'h00,0,0};
    tbl[3]  = '{1,3,5,1,1,1,8'h10,7,9'h000, 0,0,0,3,2,0,0,8'h00,0,0};
    tbl[4]  = '{1,7,5,1,1,1,8'h00,0,9'h000, 0,0,0,2,3,0,0,8'h00,0,0};
    tbl[5]  = '{1,7,7,1,0,1,8'h10,7,9'h000, 0,0,0,1,0,0,0,8'h00,0,0};
    tbl[6]  = '{0,7,0,1,0,0,8'h10,7,9'h000, 0,0,0,0,0,0,0,8'h00,0,0};
    tbl[7]  = '{1,7,0,1,0,0,8'h10,7,9'h000, 0,0,0,3,0,0,0,8'h00,0,0};
    tbl[8]  = '{1,2,0,1,0,1,8'h50,2,9'h000, 1,1,0,0,0,1,0,8'h00,0,0};
    tbl[9]  = '{1,2,0,1,0,1,8'h00,0,9'h000, 0,0,0,2,0,0,0,8'h00,1,0};
    tbl[10] = '{0,0,0,0,0,1,8'h08,0,9'h12C, 0,0,1,0,0,0,1,8'h2C,1,0};
    tbl[11] = '{1,4,0,1,0,1,8'h50,4,9'h155, 0,0,1,0,0,0,0,8'h00,1,1};
    tbl[12] = '{1,4,0,1,0,0,8'h00,0,9'h000, 0,0,0,2,0,0,0,8'h00,1,1};
    tbl[13] = '{1,0,6,0,1,1,8'h58,6,9'h180, 0,0,1,0,0,1,1,8'h80,1,1};
    tbl[14] = '{1,0,6,0,1,1,8'h08,0,9'h199, 0,0,1,0,2,0,0,8'h00,1,2};
    tbl[15] = '{0,0,0,0,0,0,8'h00,0,9'h000, 0,0,0,0,0,0,0,8'h00,1,2};
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(tbl[i].st));
      chk($sformatf("v%0d bubble", i), 32'(bus.bubble), 32'(tbl[i].bu));
      chk($sformatf("v%0d flush", i), 32'(bus.flush), 32'(tbl[i].fl));
      chk($sformatf("v%0d redirect_valid", i), 32'(bus.redirect_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("v%0d redirect_pc", i), 32'(bus.redirect_pc), 32'(tbl[i].rpc));
      if (!tbl[i].fx) begin
        chk($sformatf("v%0d fwd1_sel", i), 32'(bus.fwd1_sel), 32'(tbl[i].f1));
        chk($sformatf("v%0d fwd2_sel", i), 32'(bus.fwd2_sel), 32'(tbl[i].f2));
      end
      chk($sformatf("v%0d stall_cnt", i), 32'(bus.stall_cnt), 32'(tbl[i].sc));
      chk($sformatf("v%0d flush_cnt", i), 32'(bus.flush_cnt), 32'(tbl[i].fc));
      @(posedge clk);
      #1;
    end
    // Reset asserted in the second flush cycle.
    drive('{0,0,0,0,0,1,8'h08,0,9'h12C, 0,0,0,0,0,0,0,8'h00,0,0});
    @(negedge clk);
    chk("rst_mid redirect_valid", 32'(bus.redirect_valid), 32'd1);
    @(posedge clk);
    #1;
    drive(tbl[0]);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid flush_before_edge", 32'(bus.flush), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid flush_after", 32'(bus.flush), 32'd0);
    chk("rst_mid flush_cnt", 32'(bus.flush_cnt), 32'd0);
    chk("rst_mid stall_cnt", 32'(bus.stall_cnt), 32'd0);
    // Continuous load-use stall to drive stall_cnt into saturation.
    @(posedge clk);
    #1;
    drive('{1,2,0,1,0,1,8'h50,2,9'h000, 0,0,0,0,0,0,0,8'h00,0,0});
    @(negedge clk);
    chk("sat stall_start", 32'(bus.stall), 32'd1);
    chk("sat cnt_start", 32'(bus.stall_cnt), 32'd0);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat cnt_fffe", 32'(bus.stall_cnt), 32'h0000FFFE);
    @(posedge clk);
    @(negedge clk);
    chk("sat cnt_ffff", 32'(bus.stall_cnt), 32'h0000FFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sat cnt_hold", 32'(bus.stall_cnt), 32'h0000FFFF);
    chk("sat stall_hold", 32'(bus.stall), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
